// File: rtl/cache_writeback_buffer_if.sv
// Eviction, line-fill forwarding and RAM write-port signals of the write-back buffer.
// The master side is the cache controller plus RAM; the slave side is the buffer.
interface cache_writeback_buffer_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 32
);
    logic                      evict_valid;
    logic [RAM_ADDR_WIDTH-1:0] evict_addr;
    logic [DATA_WIDTH-1:0]     evict_data;
    logic                      evict_ready;

    logic [RAM_ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0]     fill_data_ram;
    logic [DATA_WIDTH-1:0]     fill_data;
    logic                      fill_fwd;

    logic                      ram_wr_valid;
    logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0]     ram_wr_data;
    logic                      ram_wr_ready;

    modport master (
        output evict_valid, evict_addr, evict_data, fill_addr, fill_data_ram, ram_wr_ready,
        input  evict_ready, fill_data, fill_fwd, ram_wr_valid, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input  evict_valid, evict_addr, evict_data, fill_addr, fill_data_ram, ram_wr_ready,
        output evict_ready, fill_data, fill_fwd, ram_wr_valid, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/cache_writeback_buffer.sv
// Write-back FIFO between the cache controller and RAM: coalesces evictions to the
// same word, drains in order, and forwards pending data to line fills.
module cache_writeback_buffer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cache_writeback_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WAW = RAM_ADDR_WIDTH - 2;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [WAW-1:0]        waddr_q [DEPTH];
    logic [WAW-1:0]        waddr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  pop, push, coalesce, any_hit;
    logic [PW-1:0]         hit_idx;
    logic [WAW-1:0]        evict_waddr, fill_waddr;
    logic                  unused_byte_offsets;

    assign evict_waddr         = bus.evict_addr[RAM_ADDR_WIDTH-1:2];
    assign fill_waddr          = bus.fill_addr[RAM_ADDR_WIDTH-1:2];
    assign unused_byte_offsets = ^{bus.evict_addr[1:0], bus.fill_addr[1:0]};

    assign count            = count_q;
    assign empty            = (count_q == '0);
    assign full             = (count_q == CW'(DEPTH));
    assign bus.ram_wr_valid = (count_q != '0);
    assign bus.ram_wr_addr  = {waddr_q[head_q], 2'b00};
    assign bus.ram_wr_data  = data_q[head_q];
    assign pop              = (count_q != '0) && bus.ram_wr_ready;
    assign bus.evict_ready  = !full || pop;

    // The head entry leaving this cycle is excluded so a matching eviction re-allocates.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == evict_waddr) && !(pop && (head_q == PW'(i)))) begin
                any_hit = 1'b1;
                hit_idx = PW'(i);
            end
        end
        coalesce = bus.evict_valid && any_hit;
        push     = bus.evict_valid && !any_hit && bus.evict_ready;
    end

    // Next state: pop first so a push into the freed full slot wins on the same index.
    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (coalesce) begin
            data_d[hit_idx] = bus.evict_data;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            waddr_d[tail_q] = evict_waddr;
            data_d[tail_q]  = bus.evict_data;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Zero-latency fill forwarding; the no-duplicate invariant allows at most one hit.
    always_comb begin
        bus.fill_data = bus.fill_data_ram;
        bus.fill_fwd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (waddr_q[i] == fill_waddr)) begin
                bus.fill_data = data_q[i];
                bus.fill_fwd  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer: expected RAM writes are queued by the
// stimulus and checked in order by an independent write-port monitor.
module tb_cache_writeback_buffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    cache_writeback_buffer_if #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) bus ();

    cache_writeback_buffer #(
        .DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic evict(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.evict_valid = 1'b1;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        step();
        bus.evict_valid = 1'b0;
    endtask

    // Every accepted RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.ram_wr_valid && bus.ram_wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         bus.ram_wr_addr, bus.ram_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.ram_wr_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(bus.ram_wr_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required $finish");
        $fatal(1);
    end

    initial begin
        bus.evict_valid   = 1'b0;
        bus.evict_addr    = '0;
        bus.evict_data    = '0;
        bus.fill_addr     = '0;
        bus.fill_data_ram = '0;
        bus.ram_wr_ready  = 1'b0;
        rst_n             = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_wr_valid", 64'(bus.ram_wr_valid), 64'(0));
        chk("rst_evict_ready", 64'(bus.evict_ready), 64'(1));
        chk("rst_fill_fwd", 64'(bus.fill_fwd), 64'(0));
        step();
        rst_n = 1'b1;

        // FIFO order
        expect_wr(32'h100, 32'hAAAA0001);
        expect_wr(32'h200, 32'hAAAA0002);
        expect_wr(32'h300, 32'hAAAA0003);
        evict(32'h100, 32'hAAAA0001);
        evict(32'h200, 32'hAAAA0002);
        evict(32'h300, 32'hAAAA0003);
        chk("fifo_count3", 64'(count), 64'(3));
        bus.ram_wr_ready = 1'b1;
        step();
        chk("fifo_count2", 64'(count), 64'(2));
        step();
        step();
        chk("fifo_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Full, coalesce while full, backpressure, then push into the popped slot
        expect_wr(32'h1000, 32'hB0000000);
        expect_wr(32'h1004, 32'h55555555);
        expect_wr(32'h1008, 32'hB0000002);
        expect_wr(32'h100C, 32'hB0000003);
        expect_wr(32'h500,  32'hB0000005);
        evict(32'h1000, 32'hB0000000);
        evict(32'h1004, 32'hB0000001);
        evict(32'h1008, 32'hB0000002);
        evict(32'h100C, 32'hB0000003);
        chk("full_count", 64'(count), 64'(4));
        chk("full_flag", 64'(full), 64'(1));
        chk("full_evict_ready", 64'(bus.evict_ready), 64'(0));
        evict(32'h1006, 32'h55555555);
        chk("full_coalesce_count", 64'(count), 64'(4));
        bus.evict_valid = 1'b1;
        bus.evict_addr  = 32'h500;
        bus.evict_data  = 32'hB0000005;
        #1;
        chk("stall_evict_ready", 64'(bus.evict_ready), 64'(0));
        step();
        chk("stall_count", 64'(count), 64'(4));
        chk("stall_head", 64'(bus.ram_wr_addr), 64'(32'h1000));
        bus.ram_wr_ready = 1'b1;
        #1;
        chk("pop_evict_ready", 64'(bus.evict_ready), 64'(1));
        step();
        bus.evict_valid = 1'b0;
        chk("pushpop_count", 64'(count), 64'(4));
        chk("pushpop_full", 64'(full), 64'(1));
        repeat (4) step();
        chk("full_drain_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Coalesce into an idle entry; byte offset dropped
        expect_wr(32'h240, 32'h22222222);
        evict(32'h240, 32'h11111111);
        evict(32'h242, 32'h22222222);
        chk("coalesce_count", 64'(count), 64'(1));
        bus.ram_wr_ready = 1'b1;
        step();
        chk("coalesce_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Same word as the head being popped: allocates a second entry
        expect_wr(32'h240, 32'h33333333);
        expect_wr(32'h240, 32'h44444444);
        evict(32'h240, 32'h33333333);
        bus.ram_wr_ready = 1'b1;
        evict(32'h240, 32'h44444444);
        chk("headpop_count", 64'(count), 64'(1));
        chk("headpop_data", 64'(bus.ram_wr_data), 64'(32'h44444444));
        step();
        chk("headpop_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Forwarding
        expect_wr(32'h400, 32'hDEADBEEF);
        expect_wr(32'h800, 32'h77777777);
        evict(32'h400, 32'hDEADBEEF);
        bus.fill_addr     = 32'h400;
        bus.fill_data_ram = 32'h0;
        #1;
        chk("fwd_hit_data", 64'(bus.fill_data), 64'(32'hDEADBEEF));
        chk("fwd_hit_flag", 64'(bus.fill_fwd), 64'(1));
        bus.fill_addr = 32'h402;
        #1;
        chk("fwd_offset_flag", 64'(bus.fill_fwd), 64'(1));
        step();
        bus.fill_addr     = 32'h404;
        bus.fill_data_ram = 32'h12345678;
        #1;
        chk("fwd_miss_data", 64'(bus.fill_data), 64'(32'h12345678));
        chk("fwd_miss_flag", 64'(bus.fill_fwd), 64'(0));
        step();
        bus.ram_wr_ready  = 1'b1;
        bus.evict_valid   = 1'b1;
        bus.evict_addr    = 32'h800;
        bus.evict_data    = 32'h77777777;
        bus.fill_addr     = 32'h400;
        bus.fill_data_ram = 32'h0;
        #1;
        chk("fwd_popping_data", 64'(bus.fill_data), 64'(32'hDEADBEEF));
        chk("fwd_popping_flag", 64'(bus.fill_fwd), 64'(1));
        bus.fill_addr     = 32'h800;
        bus.fill_data_ram = 32'h0BADF00D;
        #1;
        chk("fwd_incoming_data", 64'(bus.fill_data), 64'(32'h0BADF00D));
        chk("fwd_incoming_flag", 64'(bus.fill_fwd), 64'(0));
        step();
        bus.evict_valid = 1'b0;
        chk("fwd_pushpop_count", 64'(count), 64'(1));
        step();
        chk("fwd_drain_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Handshake stability under backpressure with a push every cycle
        expect_wr(32'h600, 32'h60000000);
        expect_wr(32'h604, 32'h60000001);
        expect_wr(32'h608, 32'h60000002);
        expect_wr(32'h60C, 32'h60000003);
        for (int i = 0; i < 5; i++) begin
            evict(AW'(32'h600 + 4 * i), DW'(32'h60000000 + i));
            chk("hold_addr", 64'(bus.ram_wr_addr), 64'(32'h600));
            chk("hold_data", 64'(bus.ram_wr_data), 64'(32'h60000000));
        end
        chk("hold_count", 64'(count), 64'(4));
        bus.ram_wr_ready = 1'b1;
        #1;
        chk("hold_ready_addr", 64'(bus.ram_wr_addr), 64'(32'h600));
        step();
        chk("next_head_addr", 64'(bus.ram_wr_addr), 64'(32'h604));
        chk("next_head_data", 64'(bus.ram_wr_data), 64'(32'h60000001));
        repeat (3) step();
        chk("hold_drain_empty", 64'(empty), 64'(1));
        bus.ram_wr_ready = 1'b0;

        // Reset mid-drain discards pending writes
        evict(32'h700, 32'h70000000);
        evict(32'h704, 32'h70000001);
        evict(32'h708, 32'h70000002);
        chk("prereset_count", 64'(count), 64'(3));
        bus.ram_wr_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_empty", 64'(empty), 64'(1));
        chk("midrst_wr_valid", 64'(bus.ram_wr_valid), 64'(0));
        chk("midrst_evict_ready", 64'(bus.evict_ready), 64'(1));
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("postrst_wr_valid", 64'(bus.ram_wr_valid), 64'(0));
        bus.ram_wr_ready = 1'b0;
        step();
        chk("queue_left", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_writeback_buffer.md
Name: cache_writeback_buffer

Overview:
- Write-back buffer between the two-way cache controller and main RAM.
- Captures dirty evicted words (`we_to_ram`, `evicted_ram_addr`, `evicted_word`) into a small FIFO and drains them to RAM through a valid/ready write port.
- Forwards buffered data to cache line fills, so a miss never reads stale RAM while a write-back is still pending.

Parameters:
- DATA_WIDTH, 32, word width.
- RAM_ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- evict_valid  in  1  evicted dirty word present (driven by controller `we_to_ram`)
- evict_addr  in  RAM_ADDR_WIDTH  byte address of evicted word
- evict_data  in  DATA_WIDTH  evicted word
- evict_ready  out  1  buffer can accept an eviction this cycle
- fill_addr  in  RAM_ADDR_WIDTH  byte address of the line fill being read
- fill_data_ram  in  DATA_WIDTH  word returned by RAM for fill_addr
- fill_data  out  DATA_WIDTH  word for the controller's `rd_from_ram`
- fill_fwd  out  1  fill_data sourced from the buffer
- ram_wr_valid  out  1  head entry offered to RAM
- ram_wr_addr  out  RAM_ADDR_WIDTH  head entry address
- ram_wr_data  out  DATA_WIDTH  head entry data
- ram_wr_ready  in  1  RAM accepts the write this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- **Reset.** Asynchronous on rst_n low.
  - All entry valid bits cleared; head/tail pointers 0; count 0.
  - ram_wr_valid 0, evict_ready 1, empty 1, full 0, fill_fwd 0.
  - Reset mid-operation discards all pending writes. This is accepted by the system; no partial RAM write is issued after reset.
- **Storage.** Circular FIFO of DEPTH entries {valid, addr, data}.
  - Pointers wrap modulo DEPTH.
  - Address compares use addr[RAM_ADDR_WIDTH-1:2]; the byte offset is ignored and stored as 0.
- **Pop (drain).**
  - ram_wr_valid = !empty.
  - ram_wr_addr / ram_wr_data come from the head entry and are held stable while ram_wr_valid && !ram_wr_ready.
  - Pop occurs on the clock edge where ram_wr_valid && ram_wr_ready: head entry invalidated, head pointer advances.
- **Coalesce.**
  - If evict_valid and evict_addr word-matches a valid entry that is not being popped this cycle, that entry's data is overwritten in place.
  - No allocation; count unchanged; evict_ready is ignored for this case (always accepted).
- **Push.**
  - If evict_valid, no coalesce, and evict_ready: write at tail, tail advances, count +1.
  - A match on the head entry being popped in the same cycle is not coalesced; it allocates a new entry.
- **evict_ready.**
  - evict_ready = !full || (ram_wr_valid && ram_wr_ready), i.e. a pop frees space for a same-cycle push.
  - evict_valid with !evict_ready and no coalesce: the eviction is not accepted. The producer stalls the pipeline while evict_valid && !evict_ready.
- **Simultaneous push and pop.** Both take effect; count unchanged.
  - When full, the pop slot is reused by the push.
  - When count == 1, the entry popped and the entry pushed are distinct.
- **Count.** count(next) = count + push − pop. Never exceeds DEPTH and never underflows.
- **Forwarding (combinational, zero latency).**
  - If fill_addr word-matches a valid entry: fill_data = that entry's data, fill_fwd = 1.
  - Otherwise fill_data = fill_data_ram, fill_fwd = 0.
  - Coalescing guarantees at most one match.
  - An entry popped this cycle still forwards this cycle.
  - A same-cycle incoming eviction is not forwarded.
- **Invariant.** No two valid entries hold the same word address.

Test Plan:
- **Reset state.** Assert rst_n=0 mid-drain with count=3 → immediately count=0, empty=1, ram_wr_valid=0, evict_ready=1. After release, no RAM write appears.
- **FIFO order.** Push 0x100/0xAAAA0001, 0x200/0xAAAA0002, 0x300/0xAAAA0003 with ram_wr_ready=0 → count=3. Then ram_wr_ready=1 → writes issue in order 0x100, 0x200, 0x300 on consecutive cycles, then empty=1.
- **Full/backpressure.**
  - With DEPTH=4, fill 4 entries with ram_wr_ready=0 → full=1, evict_ready=0; a 5th new address (0x500) is not accepted and count stays 4.
  - Raise ram_wr_ready the same cycle → 0x500 accepted, count stays 4, and it drains last.
- **Coalesce.**
  - Push 0x240/0x11111111, then 0x242/0x22222222 (same word) → count=1. Single RAM write: addr 0x240, data 0x22222222.
  - Repeat with the head being popped that cycle → two writes in order.
- **Forwarding.** Buffer holds 0x400/0xDEADBEEF, fill_addr=0x400, fill_data_ram=0x0 → fill_data=0xDEADBEEF, fill_fwd=1. fill_addr=0x404 with fill_data_ram=0x12345678 → fill_data=0x12345678, fill_fwd=0.
- **Handshake stability.** Hold ram_wr_ready=0 for 5 cycles with a push arriving each cycle → ram_wr_addr/data constant throughout. When ready rises, head pops and the next entry appears the following cycle.
